// File: rtl/adc_volt_bcd.sv
// ADC window averager feeding a signed 0.01 V magnitude through a serial
// double-dabble converter into four latched BCD display digits.
module adc_volt_bcd #(
    parameter int AVG_SHIFT = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] adc_data,
    input  logic       adc_valid,
    output logic       data_symbol,
    output logic [7:0] data_tens,
    output logic [7:0] data_units,
    output logic [7:0] data_decile,
    output logic [7:0] data_percentiles,
    output logic       upd_pulse,
    output logic       ovr
);

    localparam int AW = 8 + AVG_SHIFT;
    localparam int CW = AVG_SHIFT + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'((1 << AVG_SHIFT) - 1);

    typedef enum logic [1:0] {IDLE, CALC, CONV, UPDATE} state_t;

    state_t state, state_nx;

    logic [AW-1:0] acc, snap, sum_now;
    logic [CW-1:0] cnt;
    logic          win_done, take;

    logic          do_calc, do_shift, do_load;
    logic [3:0]    bit_cnt;
    logic [15:0]   bcd_r;
    logic [9:0]    bin_r, mag_r, mag_c;
    logic          neg_r, neg_c;
    logic [7:0]    avg;
    logic [8:0]    diff;
    logic [16:0]   prod;
    logic [25:0]   sh_next;

    function automatic logic [15:0] dd_adj(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++)
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        return r;
    endfunction

    assign sum_now  = acc + AW'(adc_data);
    assign win_done = adc_valid && (cnt == CNT_MAX);
    assign take     = win_done && (state == IDLE);

    // Window accumulation never stalls, whatever the converter is doing.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc  <= '0;
            cnt  <= '0;
            snap <= '0;
            ovr  <= 1'b0;
        end else begin
            ovr <= win_done && (state != IDLE);
            if (take)
                snap <= sum_now;
            if (adc_valid) begin
                if (win_done) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= sum_now;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (take) state_nx = CALC;
            CALC:    state_nx = CONV;
            CONV:    if (bit_cnt == 4'd9) state_nx = UPDATE;
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        do_calc  = (state == CALC);
        do_shift = (state == CONV);
        do_load  = (state == UPDATE);
    end

    // Offset-binary code to |V| in hundredths: full scale 128 steps = 10.00 V.
    always_comb begin
        avg   = 8'(snap >> AVG_SHIFT);
        neg_c = (avg < 8'd128);
        diff  = neg_c ? (9'd128 - {1'b0, avg}) : ({1'b0, avg} - 9'd128);
        prod  = {8'd0, diff} * 17'd1000;
        mag_c = 10'(prod >> 7);
    end

    assign sh_next = {dd_adj(bcd_r), bin_r} << 1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bcd_r   <= '0;
            bin_r   <= '0;
            mag_r   <= '0;
            neg_r   <= 1'b0;
            bit_cnt <= '0;
        end else if (do_calc) begin
            bcd_r   <= '0;
            bin_r   <= mag_c;
            mag_r   <= mag_c;
            neg_r   <= neg_c;
            bit_cnt <= '0;
        end else if (do_shift) begin
            bcd_r   <= sh_next[25:10];
            bin_r   <= sh_next[9:0];
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_symbol      <= 1'b0;
            data_tens        <= '0;
            data_units       <= '0;
            data_decile      <= '0;
            data_percentiles <= '0;
            upd_pulse        <= 1'b0;
        end else begin
            upd_pulse <= do_load;
            if (do_load) begin
                data_symbol      <= neg_r && (mag_r != 10'd0);
                data_tens        <= {4'd0, bcd_r[15:12]};
                data_units       <= {4'd0, bcd_r[11:8]};
                data_decile      <= {4'd0, bcd_r[7:4]};
                data_percentiles <= {4'd0, bcd_r[3:0]};
            end
        end
    end

endmodule
